ena_pulse_gen: RTL

- Source side of the enable-qualification link. On a one-cycle start request it drives `ena` high for exactly HOLD_CYCLES consecutive cycles.
- After each burst it forces a low gap so the downstream sustained-enable detector re-arms. Its trigger then fires once per burst.
- Provides a one-deep request queue, busy/done status and a sticky drop-error flag.
- Sits between control logic (pulse requests) and the enable-qualifying detector chain.

---
 rtl/ena_pulse_gen.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ena_pulse_gen.sv
// Enable burst source: one start request drives ena high for HOLD_CYCLES cycles,
// then forces GAP_CYCLES low cycles. Optional macro: ENA_PULSE_GEN_RETRIGGER_EN.
module ena_pulse_gen #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic clr_err,
  output logic ena,
  output logic busy,
  output logic done,
  output logic pend,
  output logic drop_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Counter counts down to zero, so a phase of N cycles loads N-1.
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             cnt_zero;
  logic             pend_d;
  logic             done_d;
  logic             drop_set;
  logic             drop_d;
  logic             ena_d;
  logic             busy_d;

  assign cnt_zero = (cnt == '0);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d  = state;
    cnt_d    = cnt;
    pend_d   = pend;
    done_d   = 1'b0;
    drop_set = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end

      HOLD: begin
`ifdef ENA_PULSE_GEN_RETRIGGER_EN
        // A start during the burst restarts the hold window instead of queuing.
        if (start) begin
          cnt_d = HOLD_LOAD;
        end else if (cnt_zero) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt - CNT_ONE;
        end
`else
        if (start) begin
          if (pend) drop_set = 1'b1;
          else      pend_d   = 1'b1;
        end
        if (cnt_zero) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt - CNT_ONE;
        end
`endif
      end

      GAP: begin
        if (!cnt_zero) begin
          cnt_d = cnt - CNT_ONE;
          if (start) begin
            if (pend) drop_set = 1'b1;
            else      pend_d   = 1'b1;
          end
        end else if (pend || start) begin
          // The queued request is serviced; a coincident start re-queues behind it.
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
          pend_d  = pend && start;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end
    endcase

    ena_d  = (state_d == HOLD);
    busy_d = (state_d != IDLE);

    // A new loss outranks a same-cycle clear so no drop goes unreported.
    if (drop_set)     drop_d = 1'b1;
    else if (clr_err) drop_d = 1'b0;
    else              drop_d = drop_err;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      ena      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pend     <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      ena      <= ena_d;
      busy     <= busy_d;
      done     <= done_d;
      pend     <= pend_d;
      drop_err <= drop_d;
    end
  end

endmodule
